// File: rtl/pe_array_sched_pkg.sv
// Shared types and constants for the PE-array weight/compute/drain scheduler.
package pe_array_sched_pkg;

  localparam int CONF_PE_ROW = 2;
  localparam int CONF_PE_COL = 4;
  localparam int ROW_W  = (CONF_PE_ROW > 1) ? $clog2(CONF_PE_ROW) : 1;
  localparam int STEP_W = 4;

  typedef enum logic [2:0] {
    A_MODE = 3'd0,
    B_MODE = 3'd1,
    C_MODE = 3'd2,
    D_MODE = 3'd3,
    E_MODE = 3'd4
  } PE_weight_mode_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COMP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } sched_state_t;

  // MAC steps per pass; the 5x5 kernel is split A/B/C/D = 9+6+6+4 = 25 taps.
  function automatic logic [STEP_W-1:0] pass_len(input PE_weight_mode_t m);
    case (m)
      A_MODE:  pass_len = 4'd9;
      B_MODE:  pass_len = 4'd6;
      C_MODE:  pass_len = 4'd6;
      D_MODE:  pass_len = 4'd4;
      default: pass_len = 4'd9;
    endcase
  endfunction

  function automatic PE_weight_mode_t next_pass(input PE_weight_mode_t m);
    case (m)
      A_MODE:  next_pass = B_MODE;
      B_MODE:  next_pass = C_MODE;
      C_MODE:  next_pass = D_MODE;
      default: next_pass = m;
    endcase
  endfunction

endpackage

// File: rtl/pe_array_sched_if.sv
// Job, weight-fetch, compute and psum-drain signals between scheduler and PE datapath.
interface pe_array_sched_if;
  import pe_array_sched_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_kernel5;
  logic [7:0]        cfg_tiles;
  logic              w_req;
  logic              w_ack;
  logic [ROW_W-1:0]  w_row;
  PE_weight_mode_t   pe_mode;
  logic              fm_valid;
  logic              pe_en;
  logic              pe_first;
  logic              pe_last;
  logic              psum_fifo_full;
  logic              psum_push;
  logic              busy;
  logic              done;
  logic [7:0]        tile_cnt;

  modport master (
    input  cfg_valid, cfg_kernel5, cfg_tiles, w_ack, fm_valid, psum_fifo_full,
    output cfg_ready, w_req, w_row, pe_mode, pe_en, pe_first, pe_last,
           psum_push, busy, done, tile_cnt
  );

  modport slave (
    output cfg_valid, cfg_kernel5, cfg_tiles, w_ack, fm_valid, psum_fifo_full,
    input  cfg_ready, w_req, w_row, pe_mode, pe_en, pe_first, pe_last,
           psum_push, busy, done, tile_cnt
  );

endinterface

// File: rtl/pe_array_sched.sv
// Sequences per-tile weight loads, MAC passes and psum drains for the PE array.
module pe_array_sched
  import pe_array_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  pe_array_sched_if.master  io_sched
);

  sched_state_t    r_state;
  logic            r_kernel5;
  logic [7:0]      r_tiles;
  PE_weight_mode_t r_mode;
  logic [ROW_W-1:0] r_row;
  logic [STEP_W-1:0] r_step;
  logic [7:0]      r_tile_cnt;

  logic            w_pe_en;
  logic            w_push;
  logic            w_row_last;
  logic            w_pass_end;
  logic            w_last_pass;
  logic            w_first_pass;
  PE_weight_mode_t w_start_mode;

  assign w_pe_en      = (r_state == S_COMP) && io_sched.fm_valid;
  assign w_push       = (r_state == S_DRAIN) && !io_sched.psum_fifo_full;
  assign w_row_last   = (r_row == ROW_W'(CONF_PE_ROW - 1));
  assign w_pass_end   = (r_step == (pass_len(r_mode) - 4'd1));
  assign w_last_pass  = (r_mode == D_MODE) || (r_mode == E_MODE);
  assign w_first_pass = (r_mode == A_MODE) || (r_mode == E_MODE);
  assign w_start_mode = r_kernel5 ? A_MODE : E_MODE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_kernel5  <= 1'b0;
      r_tiles    <= 8'd0;
      r_mode     <= A_MODE;
      r_row      <= '0;
      r_step     <= '0;
      r_tile_cnt <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_sched.cfg_valid) begin
            r_kernel5  <= io_sched.cfg_kernel5;
            r_tiles    <= io_sched.cfg_tiles;
            r_mode     <= io_sched.cfg_kernel5 ? A_MODE : E_MODE;
            r_tile_cnt <= 8'd0;
            r_row      <= '0;
            r_step     <= '0;
            r_state    <= (io_sched.cfg_tiles == 8'd0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (io_sched.w_ack) begin
            if (w_row_last) begin
              r_row   <= '0;
              r_step  <= '0;
              r_state <= S_COMP;
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end
        end
        S_COMP: begin
          if (w_pe_en) begin
            if (w_pass_end) begin
              r_step <= '0;
              if (w_last_pass) begin
                r_state <= S_DRAIN;
              end else begin
                r_mode  <= next_pass(r_mode);
                r_state <= S_LOAD;
              end
            end else begin
              r_step <= r_step + STEP_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_push) begin
            if (w_row_last) begin
              r_row      <= '0;
              r_tile_cnt <= r_tile_cnt + 8'd1;
              // Another tile restarts from the first pass of the kernel.
              if ((r_tile_cnt + 8'd1) < r_tiles) begin
                r_mode  <= w_start_mode;
                r_state <= S_LOAD;
              end else begin
                r_state <= S_DONE;
              end
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_sched.cfg_ready = (r_state == S_IDLE);
  assign io_sched.busy      = (r_state != S_IDLE);
  assign io_sched.done      = (r_state == S_DONE);
  assign io_sched.w_req     = (r_state == S_LOAD);
  assign io_sched.w_row     = r_row;
  assign io_sched.pe_mode   = r_mode;
  assign io_sched.pe_en     = w_pe_en;
  assign io_sched.pe_first  = w_pe_en && w_first_pass;
  assign io_sched.pe_last   = w_pe_en && w_last_pass;
  assign io_sched.psum_push = w_push;
  assign io_sched.tile_cnt  = r_tile_cnt;

endmodule
